// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap accumulator: state encoding, nibble count, signed limits.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int acc_w);
    return acc_w / 4;
  endfunction

  // Limits returned as raw bit patterns; callers truncate to their own width.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fir_nibble_acc_cla.sv
// 4-bit carry-lookahead adder: one nibble of the serial accumulation per cycle.
module cla (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];

endmodule

// File: rtl/fir_nibble_acc.sv
// Nibble-serial tap accumulator: sums TAPS signed products through one 4-bit CLA.
// Optional saturation on signed overflow is enabled by defining FIR_ACC_SAT_EN.
module fir_nibble_acc
  import fir_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 20,
  parameter int TAPS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int NIB = nib_count(ACC_W);
  localparam int NCW = $clog2(NIB + 1);
  localparam int TCW = $clog2(TAPS + 1);

  if ((ACC_W % 4) != 0 || ACC_W < IN_W || TAPS < 1) begin : g_param_err
    $error("fir_nibble_acc: ACC_W must be a multiple of 4, ACC_W >= IN_W, TAPS >= 1");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_op;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_carry;
  logic [NCW-1:0]          r_nib;
  logic [TCW-1:0]          r_term;

  logic [3:0]              w_a;
  logic [3:0]              w_b;
  logic [3:0]              w_sum;
  logic                    w_c4;
  logic signed [ACC_W-1:0] w_acc_new;
  logic signed [ACC_W-1:0] w_acc_fin;
  logic                    w_last_nib;
  logic                    w_last_term;

  assign w_last_nib  = (r_nib == NCW'(NIB - 1));
  assign w_last_term = (r_term == TCW'(TAPS - 1));

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (r_nib == NCW'(k)) begin
        w_a = r_acc[4*k +: 4];
        w_b = r_op[4*k +: 4];
      end
    end
  end

  cla u_cla (
    .i_a (w_a),
    .i_b (w_b),
    .i_c (r_carry),
    .o_s (w_sum),
    .o_c (w_c4)
  );

  always_comb begin
    w_acc_new = r_acc;
    for (int k = 0; k < NIB; k++) begin
      if (r_nib == NCW'(k)) w_acc_new[4*k +: 4] = w_sum;
    end
  end

`ifdef FIR_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(sat_min(ACC_W));

  logic r_sat;
  logic w_ovf;

  // Old acc MSB is intact until the last nibble writes it, so it is the pre-add sign.
  assign w_ovf     = w_last_nib && (r_op[ACC_W-1] == r_acc[ACC_W-1])
                   && (w_sum[3] != r_acc[ACC_W-1]);
  assign w_acc_fin = w_ovf ? (r_acc[ACC_W-1] ? SMIN : SMAX) : w_acc_new;
  assign out_sat   = r_sat && (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (r_state == ST_ADD && w_ovf) begin
      r_sat <= 1'b1;
    end else if (r_state == ST_DONE && out_ready) begin
      r_sat <= 1'b0;
    end
  end
`else
  assign w_acc_fin = w_acc_new;
  assign out_sat   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_ADD;
      ST_ADD:  if (w_last_nib) w_state_nxt = w_last_term ? ST_DONE : ST_IDLE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_op       <= '0;
      r_out_data <= '0;
      r_carry    <= 1'b0;
      r_nib      <= '0;
      r_term     <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= ACC_W'(in_data);
            r_carry <= 1'b0;
            r_nib   <= '0;
          end
        end
        ST_ADD: begin
          r_acc   <= w_acc_fin;
          r_carry <= w_c4;
          r_nib   <= w_last_nib ? '0 : r_nib + 1'b1;
          if (w_last_nib) begin
            r_term <= r_term + 1'b1;
            if (w_last_term) r_out_data <= w_acc_fin;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc  <= '0;
            r_term <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_out_data;

endmodule
